load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's MEM stage and data_memory, directly upstream of the memory.
- Converts core load/store requests of byte, half, word and doubleword size into 8-byte-aligned 64-bit memory accesses.
- Sub-word stores use a read-modify-write sequence. Loads are lane-extracted and sign- or zero-extended.
- Misaligned accesses are rejected with an error response and never reach memory.

Parameters:
- XLEN, 64, data and address width.
- ERR_ON_MISALIGN, 1: 1 = reject misaligned accesses; 0 = force-align (clear the low address bits per size).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  LSU can accept a request (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- req_unsigned  in  1  zero-extend loads (lbu/lhu/lwu)
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load result; 0 for stores
- resp_err  out  1  misaligned access, valid with resp_valid
- mem_read  out  1  to data_memory
- mem_write  out  1  to data_memory; written on the next clk rise
- mem_address  out  XLEN  byte address with bits [2:0] forced to 0
- mem_write_data  out  XLEN  full 64-bit word to write
- mem_read_data  in  XLEN  combinational read data from memory

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE
  - all registered fields = 0
  - req_ready = 1
  - resp_valid, resp_err, mem_read, mem_write = 0
  - mem_address, mem_write_data, resp_rdata = 0
- Memory-side outputs are decoded from registered state only, so an asynchronous reset deasserts them immediately.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we, size, unsigned, addr and wdata.
  - Misaligned (addr[size-1:0] != 0, with ERR_ON_MISALIGN = 1): go to RESP with err = 1.
  - Load -> LOAD.
  - Store, size 3 -> STORE.
  - Store, size < 3 -> RMW_RD.
- LOAD: mem_read = 1. Capture the extracted and extended lane of mem_read_data into the rdata register. -> RESP.
- STORE: mem_write = 1, mem_write_data = wdata. -> RESP.
- RMW_RD: mem_read = 1. Capture mem_read_data into the word register. -> RMW_WR.
- RMW_WR: mem_write = 1. mem_write_data = word register with lanes [addr[2:0] +: 2^size bytes] replaced by the low bytes of wdata. -> RESP.
- RESP: resp_valid = 1 for exactly one cycle; resp_rdata and resp_err are valid. -> IDLE. No backpressure on the response.
- Latency, measured from the accept edge to resp_valid high:
  - Load or dword store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Misaligned: 1 cycle.
- Lane rule: little-endian; lane = addr[2:0].
  - Signed load: replicate bit (8·2^size − 1) of the extracted field into the upper bits.
  - Unsigned load: zero-fill the upper bits.
  - Size-3 loads ignore req_unsigned.
- Only one request is in flight. req_valid outside IDLE is ignored; the core must hold its request until it sees req_ready.
- mem_read and mem_write are never asserted in the same cycle. Neither is asserted on a misaligned request.
- Reset during RMW_RD or RMW_WR: mem_write drops asynchronously, no memory write occurs, state returns to IDLE, and no resp_valid is issued.
- Back-to-back: a new request can be accepted in the IDLE cycle that follows RESP. The minimum spacing between accepts is 3 cycles for a load.

Decomposition:
- Shared package lsu_pkg:
  - SIZE_B/H/W/D encodings (0..3).
  - State enum with localparams for the six states.
  - LANE_BYTES = 8.
- Sub-module lsu_lane_align (combinational):
  - Inputs: word, lane, size, unsigned, store data.
  - Outputs: extended load value and merged store word.
- The parent holds the FSM and all registers.

Test Plan:
- Load extension: preload word @0x8 = 0x8877665544332211.
  - lb @0xF -> resp_rdata = 0xFFFFFFFFFFFFFF88.
  - lbu @0xF -> 0x88.
  - lw @0xC -> 0xFFFFFFFF88776655.
  - ld @0x8 -> 0x8877665544332211.
  - Each load: resp_valid 2 cycles after accept.
- Sub-word store: same preload, sh @0xA with wdata 0xBEEF.
  - One mem_read cycle, then one mem_write cycle with data 0x88776655BEEF2211.
  - Subsequent ld @0x8 returns 0x88776655BEEF2211.
  - resp_valid 3 cycles after accept.
- Dword store: sd @0x10 with 0x0123456789ABCDEF.
  - No mem_read; a single mem_write to address 0x10.
  - ld @0x10 returns the same value.
- Misaligned: lw @0x6, then sh @0x3.
  - Each gives resp_err = 1 and resp_rdata = 0 one cycle after accept.
  - mem_read and mem_write stay 0 throughout.
- Reset mid-RMW: sb @0x8 with 0xAA; pull rst_n low during RMW_WR.
  - mem_write falls low immediately and the word is unchanged.
  - After release, req_ready = 1 and resp_valid was never pulsed.
- Handshake: hold req_valid continuously with 3 loads queued.
  - req_ready high only in IDLE.
  - Exactly 3 resp_valid pulses, each accepted request counted once.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states,
// and small helpers for lane masks.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam int LANE_BYTES = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_STORE  = 3'd2;
  localparam logic [2:0] ST_RMW_RD = 3'd3;
  localparam logic [2:0] ST_RMW_WR = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD   = ST_LOAD,
    S_STORE  = ST_STORE,
    S_RMW_RD = ST_RMW_RD,
    S_RMW_WR = ST_RMW_WR,
    S_RESP   = ST_RESP
  } lsu_state_t;

  // Address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] low_mask(
    input logic [1:0] size
  );
    unique case (size)
      SIZE_B:  low_mask = 3'b000;
      SIZE_H:  low_mask = 3'b001;
      SIZE_W:  low_mask = 3'b011;
      default: low_mask = 3'b111;
    endcase
  endfunction

  // Byte-enable pattern of an access, before shifting to its lane.
  function automatic logic [7:0] byte_mask(
    input logic [1:0] size
  );
    unique case (size)
      SIZE_B:  byte_mask = 8'h01;
      SIZE_H:  byte_mask = 8'h03;
      SIZE_W:  byte_mask = 8'h0F;
      default: byte_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane extraction/extension for loads and byte merge for stores.
// Ports: word, lane, size, uns, wdata in; load_val, store_word out.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      lane,
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_val,
  output logic [XLEN-1:0] store_word
);

  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] wsh;
  logic [7:0]      bm;

  always_comb begin
    sh  = word >> {lane, 3'b000};
    wsh = wdata << {lane, 3'b000};
    bm  = byte_mask(size) << lane;

    load_val = sh;
    unique case (size)
      SIZE_B: load_val =
        {{(XLEN-8){~uns & sh[7]}}, sh[7:0]};
      SIZE_H: load_val =
        {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
      SIZE_W: load_val =
        {{(XLEN-32){~uns & sh[31]}}, sh[31:0]};
      default: load_val = sh;
    endcase

    store_word = word;
    for (int i = 0; i < LANE_BYTES; i++) begin
      if (bm[i]) store_word[8*i +: 8] = wsh[8*i +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sized core requests to aligned 64-bit memory ops.
// Ports: core req/resp handshake, data_memory read/write interface.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN            = 64,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  input  logic [XLEN-1:0] mem_read_data
);

  lsu_state_t      state_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] word_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic            mis;
  logic [2:0]      lmask;
  logic [XLEN-1:0] al_word;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] store_word;

  assign lmask = low_mask(req_size);
  assign mis   = ERR_ON_MISALIGN &&
                 (|(req_addr[2:0] & lmask));

  // Loads extract straight from memory; merges use the held word.
  assign al_word = (state_q == S_LOAD) ?
                   mem_read_data : word_q;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .word       (al_word),
    .lane       (addr_q[2:0]),
    .size       (size_q),
    .uns        (uns_q),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= {req_addr[XLEN-1:3],
                        req_addr[2:0] & ~lmask};
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= mis;
            if (mis)
              state_q <= S_RESP;
            else if (!req_we)
              state_q <= S_LOAD;
            else if (req_size == SIZE_D)
              state_q <= S_STORE;
            else
              state_q <= S_RMW_RD;
          end
        end
        S_LOAD: begin
          rdata_q <= load_val;
          state_q <= S_RESP;
        end
        S_STORE:  state_q <= S_RESP;
        S_RMW_RD: begin
          word_q  <= mem_read_data;
          state_q <= S_RMW_WR;
        end
        S_RMW_WR: state_q <= S_RESP;
        S_RESP:   state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign mem_read    = (state_q == S_LOAD) ||
                       (state_q == S_RMW_RD);
  assign mem_write   = (state_q == S_STORE) ||
                       (state_q == S_RMW_WR);
  assign mem_address = {addr_q[XLEN-1:3], 3'b000};

  always_comb begin
    mem_write_data = '0;
    if (state_q == S_STORE)
      mem_write_data = wdata_q;
    else if (state_q == S_RMW_WR)
      mem_write_data = store_word;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference model, per-cycle
// compare process and directed vectors with literal expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;

  load_store_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  logic [63:0] tmem [0:7];
  assign mem_read_data = tmem[mem_address[5:3]];
  always @(posedge clk)
    if (mem_write) tmem[mem_address[5:3]] <= mem_write_data;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          acc;
  } txn_t;

  txn_t        q[$];
  logic [7:0]  rb [0:63];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          cur_nr = 0;
  int          cur_nw = 0;
  int          nresp = 0;
  logic [63:0] last_rdata;
  logic        last_err;
  int          last_lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic bit is_mis(input txn_t t);
    int n = 1 << t.sz;
    return (int'(t.addr[5:0]) % n) != 0;
  endfunction

  function automatic logic [63:0] ref_load(input txn_t t);
    logic [63:0] v = '0;
    int n = 1 << t.sz;
    int a = int'(t.addr[5:0]);
    for (int i = 0; i < n; i++) v[8*i +: 8] = rb[a + i];
    if (!t.uns && n < 8 && v[8*n-1])
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] ref_word(input txn_t t);
    logic [63:0] w;
    int n = 1 << t.sz;
    int base = int'(t.addr[5:3]) * 8;
    int off = int'(t.addr[2:0]);
    for (int i = 0; i < 8; i++) w[8*i +: 8] = rb[base + i];
    for (int i = 0; i < n; i++)
      w[8*(off+i) +: 8] = t.wdata[8*i +: 8];
    return w;
  endfunction

  always @(negedge clk) begin : cmp
    txn_t t;
    bit m;
    int n;
    if (rst_n) begin
      chk("ready", {63'd0, req_ready}, {63'd0, q.size() == 0});
      if (mem_read && mem_write)
        chk("rd_wr_excl", 64'd1, 64'd0);
      if (mem_read || mem_write) begin
        if (q.size() == 0) begin
          chk("stray_mem_op", 64'd1, 64'd0);
        end else begin
          chk("mem_addr", mem_address,
              {q[0].addr[63:3], 3'b000});
          if (mem_read) cur_nr++;
          if (mem_write) begin
            cur_nw++;
            chk("wdata", mem_write_data, ref_word(q[0]));
          end
        end
      end
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("stray_resp", 64'd1, 64'd0);
        end else begin
          t = q.pop_front();
          m = is_mis(t);
          n = m ? 1 : (!t.we || t.sz == 2'd3) ? 2 : 3;
          chk("err", {63'd0, resp_err}, {63'd0, m});
          chk("rdata", resp_rdata,
              (m || t.we) ? 64'd0 : ref_load(t));
          chk("latency", 64'(cyc - t.acc), 64'(n));
          chk("n_read", 64'(cur_nr),
              (m || (t.we && t.sz == 2'd3)) ? 64'd0 : 64'd1);
          chk("n_write", 64'(cur_nw),
              (m || !t.we) ? 64'd0 : 64'd1);
          if (!m && t.we)
            for (int i = 0; i < (1 << t.sz); i++)
              rb[int'(t.addr[5:0]) + i] = t.wdata[8*i +: 8];
          last_rdata = resp_rdata;
          last_err = resp_err;
          last_lat = cyc - t.acc;
          nresp++;
        end
        cur_nr = 0;
        cur_nw = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [63:0] a,
                       input logic [63:0] wd, input bit keep);
    txn_t t;
    int n = 0;
    @(negedge clk);
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 64'd1, 64'd0);
      req_valid = 1'b0;
      return;
    end
    t.we = we; t.sz = sz; t.uns = uns;
    t.addr = a; t.wdata = wd; t.acc = cyc;
    @(posedge clk);
    q.push_back(t);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("resp_timeout", 64'd1, 64'd0);
      q.delete();
    end
  endtask

  task automatic op(input logic we, input logic [1:0] sz,
                    input logic uns, input logic [63:0] a,
                    input logic [63:0] wd);
    issue(we, sz, uns, a, wd, 1'b0);
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=hang expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int r0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < 8; i++) tmem[i] = '0;
    for (int i = 0; i < 64; i++) rb[i] = 8'h00;
    tmem[1] = 64'h8877665544332211;
    for (int i = 0; i < 8; i++) rb[8 + i] = 8'(8'h11 * (i + 1));

    #12;
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_mem_read", {63'd0, mem_read}, 64'd0);
    chk("rst_mem_write", {63'd0, mem_write}, 64'd0);
    chk("rst_mem_addr", mem_address, 64'd0);
    chk("rst_mem_wdata", mem_write_data, 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op(1'b0, 2'd0, 1'b0, 64'hF, 64'd0);
    chk("lb_F", last_rdata, 64'hFFFFFFFFFFFFFF88);
    chk("lb_lat", 64'(last_lat), 64'd2);
    op(1'b0, 2'd0, 1'b1, 64'hF, 64'd0);
    chk("lbu_F", last_rdata, 64'h88);
    op(1'b0, 2'd2, 1'b0, 64'hC, 64'd0);
    chk("lw_C", last_rdata, 64'hFFFFFFFF88776655);
    op(1'b0, 2'd3, 1'b1, 64'h8, 64'd0);
    chk("ld_8", last_rdata, 64'h8877665544332211);

    op(1'b1, 2'd1, 1'b0, 64'hA, 64'hBEEF);
    chk("sh_lat", 64'(last_lat), 64'd3);
    chk("sh_mem", tmem[1], 64'h88776655BEEF2211);
    op(1'b0, 2'd3, 1'b0, 64'h8, 64'd0);
    chk("ld_8_after_sh", last_rdata, 64'h88776655BEEF2211);
    op(1'b0, 2'd1, 1'b1, 64'hE, 64'd0);
    chk("lhu_E", last_rdata, 64'h8877);
    op(1'b0, 2'd1, 1'b0, 64'hA, 64'd0);
    chk("lh_A", last_rdata, 64'hFFFFFFFFFFFFBEEF);

    op(1'b1, 2'd3, 1'b0, 64'h10, 64'h0123456789ABCDEF);
    chk("sd_lat", 64'(last_lat), 64'd2);
    op(1'b0, 2'd3, 1'b0, 64'h10, 64'd0);
    chk("ld_10", last_rdata, 64'h0123456789ABCDEF);

    op(1'b0, 2'd2, 1'b0, 64'h6, 64'd0);
    chk("lw_6_err", {63'd0, last_err}, 64'd1);
    chk("lw_6_rdata", last_rdata, 64'd0);
    chk("lw_6_lat", 64'(last_lat), 64'd1);
    op(1'b1, 2'd1, 1'b0, 64'h3, 64'h1234);
    chk("sh_3_err", {63'd0, last_err}, 64'd1);
    chk("sh_3_lat", 64'(last_lat), 64'd1);

    r0 = nresp;
    issue(1'b1, 2'd0, 1'b0, 64'h8, 64'hAA, 1'b0);
    n = 0;
    while (!mem_write && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rmw_wr_seen", {63'd0, mem_write}, 64'd1);
    rst_n = 1'b0;
    q.delete();
    cur_nr = 0;
    cur_nw = 0;
    #1;
    chk("rst_drop_write", {63'd0, mem_write}, 64'd0);
    chk("rst_ready_mid", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_resp", 64'(nresp - r0), 64'd0);
    chk("rst_mem_kept", tmem[1], 64'h88776655BEEF2211);

    r0 = nresp;
    issue(1'b0, 2'd3, 1'b0, 64'h8, 64'd0, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 64'h9, 64'd0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 64'h10, 64'd0, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("hs_count", 64'(nresp - r0), 64'd3);
    chk("hs_lw_10", last_rdata, 64'hFFFFFFFF89ABCDEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
